// File: rtl/mc_control_fsm.sv
// Main control sequencer for the multi-cycle core: walks each instruction through fetch/decode/execute/memory/writeback.
// Latency: decodes are combinational from the registered state; one state per clock, 2-5 cycles per instruction.
// Backpressure: none; the sequence is fixed by opcode and there is no stall input.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t           state_q;
    state_t           state_d;
    logic             pc_en_raw;
    logic             mem_write_raw;
    logic             ir_write_raw;
    logic             reg_write_raw;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // State register: reset returns to FETCH, abandoning any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode; everything not named in a state stays 0.
    always_comb begin
        state_d       = S_FETCH;
        pc_en_raw     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read     = 1'b1;
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b01;
                pc_en_raw    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // IR is still stable here, so lw/sw are told apart without latching opcode.
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en_raw = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en_raw = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write strobes are squashed while reset is held so an abandoned instruction leaves no partial write.
    assign pc_en     = pc_en_raw     & ~rst;
    assign mem_write = mem_write_raw & ~rst;
    assign ir_write  = ir_write_raw  & ~rst;
    assign reg_write = reg_write_raw & ~rst;

    // Retired-instruction counter: bumps on the edge leaving a final state, wraps naturally, reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        pc_en, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cnt  = 0;
    int          m_state = 0;
    int          seq[$];

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .halted(halted), .state(state),
        .instr_retired(instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level view: the state walk an opcode takes, start to finish.
    function automatic void build_path(input logic [5:0] op);
        seq = {};
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            OP_LW:    begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            OP_SW:    begin seq.push_back(2); seq.push_back(5); end
            OP_RTYPE: begin seq.push_back(6); seq.push_back(7); end
            OP_BEQ:   seq.push_back(8);
            OP_ADDI:  begin seq.push_back(9); seq.push_back(10); end
            OP_J:     seq.push_back(11);
            OP_HALT:  seq.push_back(12);
            default:  ;
        endcase
    endfunction

    function automatic bit is_real(input logic [5:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_HALT};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs per signal, stated as the set of states in which each one is active.
    task automatic check_cycle(input int s, input logic z, input logic r);
        chk("state",      32'(state),      32'(s));
        chk("pc_en",      32'(pc_en),      32'(!r && (s == 0 || s == 11 || (s == 8 && z))));
        chk("iord",       32'(iord),       32'(s inside {3, 5}));
        chk("mem_read",   32'(mem_read),   32'(s inside {0, 3}));
        chk("mem_write",  32'(mem_write),  32'(!r && s == 5));
        chk("ir_write",   32'(ir_write),   32'(!r && s == 0));
        chk("reg_dst",    32'(reg_dst),    32'(s == 7));
        chk("mem_to_reg", 32'(mem_to_reg), 32'(s == 4));
        chk("reg_write",  32'(reg_write),  32'(!r && s inside {4, 7, 10}));
        chk("alu_src_a",  32'(alu_src_a),  32'(s inside {2, 6, 8, 9}));
        chk("alu_src_b",  32'(alu_src_b),  (s == 0) ? 32'd1 : (s == 1) ? 32'd3 : (s inside {2, 9}) ? 32'd2 : 32'd0);
        chk("alu_op",     32'(alu_op),     (s == 6) ? 32'd2 : (s == 8) ? 32'd1 : 32'd0);
        chk("pc_source",  32'(pc_source),  (s == 8) ? 32'd1 : (s == 11) ? 32'd2 : 32'd0);
        chk("halted",     32'(halted),     32'(s == 12));
        chk("retired",    instr_retired,   m_cnt);
    endtask

    // One instruction; zsel<0 randomizes zero each cycle; abort_at pulses rst at that step.
    task automatic run_instr(input logic [5:0] op, input int zsel, input int abort_at);
        build_path(op);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            opcode = op;
            zero   = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            rst    = (i == abort_at);
            m_state = seq[i];
            #1 check_cycle(seq[i], zero, rst);
            @(posedge clk);
            if (rst) begin
                m_cnt   = 0;
                m_state = 0;
                return;
            end
        end
        if (op == OP_HALT) m_state = 12;
        else begin
            m_state = 0;
            if (is_real(op)) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = 1'b0;
            opcode = 6'($urandom);
            zero   = 1'($urandom_range(0, 1));
            #1 check_cycle(12, zero, 1'b0);
            @(posedge clk);
        end
    endtask

    task automatic do_reset(input int n, input bit known);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = 1'b1;
            opcode = 6'($urandom);
            zero   = 1'($urandom_range(0, 1));
            #1 if (known) check_cycle(m_state, zero, 1'b1);
            @(posedge clk);
            m_state = 0;
            m_cnt   = 0;
            known   = 1'b1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_RTYPE;
            3: op = OP_BEQ;
            4: op = OP_ADDI;
            5: op = OP_J;
            6: op = (($urandom_range(0, 3)) == 0) ? OP_HALT : OP_RTYPE;
            default: begin
                op = 6'($urandom);
                while (is_real(op)) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    initial begin
        rst    = 1'b1;
        opcode = 6'd0;
        zero   = 1'b0;
        do_reset(2, 1'b0);

        // Directed walk through each instruction class.
        run_instr(OP_RTYPE, 0, -1);
        run_instr(OP_LW, 0, -1);
        run_instr(OP_BEQ, 1, -1);
        run_instr(OP_BEQ, 0, -1);
        run_instr(OP_ADDI, 1, -1);
        run_instr(6'b010101, 0, -1);
        run_instr(OP_HALT, 0, -1);
        hold_halt(10);
        do_reset(1, 1'b1);

        run_instr(OP_SW, 0, -1);
        run_instr(OP_SW, 0, -1);
        run_instr(OP_SW, 0, -1);
        run_instr(OP_J, 0, -1);
        // Reset lands while in MEMWR: no write, counter cleared.
        run_instr(OP_SW, 0, 3);
        run_instr(OP_RTYPE, 0, -1);

        // Randomized instruction stream with occasional halts and mid-instruction resets.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int ab;
            op = pick_op();
            ab = -1;
            if ($urandom_range(0, 19) == 0) begin
                build_path(op);
                ab = int'($urandom_range(0, seq.size() - 1));
            end
            run_instr(op, -1, ab);
            if (op == OP_HALT && ab < 0) begin
                hold_halt(int'($urandom_range(1, 6)));
                do_reset(int'($urandom_range(1, 2)), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multi-cycle CPU core.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives every datapath enable and mux select: PC, IR, memory, register file, ALU.
- Sits between the instruction register, which supplies opcode, and the datapath, which consumes the control strobes and returns the ALU zero flag. The top-level bench only drives clk/rst and observes pc/inst.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  inst[31:26] from instruction register; valid from DECODE onward
- zero  input  1  ALU zero flag; sampled in BRANCH
- pc_en  output  1  PC register write enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  output  1  writeback data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = rs
- alu_src_b  output  2  ALU B operand: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- halted  output  1  high while in HALT
- state  output  4  current state encoding, for debug
- instr_retired  output  CNT_W  count of completed instructions

Behaviour:
- Moore machine: all control outputs are combinational decodes of the registered state, except pc_en.
- pc_en = (state==FETCH) | (state==JUMP) | ((state==BRANCH) & zero).
- Outputs not listed for a state are 0.
- While rst is high: next state = FETCH, instr_retired <= 0, all write strobes (pc_en, mem_write, ir_write, reg_write) forced to 0. Reset asserted mid-instruction abandons it with no partial write.
- State encodings and active outputs:
  - FETCH(0): mem_read, ir_write, alu_src_b=01, alu_op=00, pc_source=00, pc_en. Next: DECODE.
  - DECODE(1): alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode:
    - 100011 lw / 101011 sw -> MEMADR
    - 000000 R-type -> EXEC
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDI_EX
    - 000010 j -> JUMP
    - 111111 -> HALT
    - any other opcode -> FETCH (treated as NOP, not counted)
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): mem_read, iord=1. Next: MEMWB.
  - MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write. Next: FETCH.
  - MEMWR(5): mem_write, iord=1. Next: FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: RTYPE_WB.
  - RTYPE_WB(7): reg_dst=1, mem_to_reg=0, reg_write. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. Next: FETCH.
  - ADDI_EX(9): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
  - ADDI_WB(10): reg_dst=0, mem_to_reg=0, reg_write. Next: FETCH.
  - JUMP(11): pc_source=10. Next: FETCH.
  - HALT(12): halted=1, all strobes 0. Stays until rst.
  - Encodings 13–15: next = FETCH, outputs all 0.
- opcode is sampled in DECODE and again in MEMADR. The datapath holds IR stable after FETCH; the FSM does not latch opcode.
- Cycles per instruction:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - undefined opcode 2
- instr_retired increments by 1 on the clock edge leaving MEMWB, MEMWR, RTYPE_WB, BRANCH (taken or not), ADDI_WB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Not incremented for undefined opcodes or in HALT.
  - rst has priority over increment.

Test Plan:
- Reset then opcode=000000 held: state sequence 0,1,6,7,0. reg_write=1, reg_dst=1 only in state 7. instr_retired=1 after 4 cycles.
- lw (100011): states 0,1,2,3,4,0. mem_read high in states 0 and 3. iord=1 only in 3. reg_write with mem_to_reg=1 in 4. Total 5 cycles.
- beq (000100) twice, zero=1 then zero=0: pc_en=1 in BRANCH only on the first pass. instr_retired increments on both.
- Opcode 010101 (undefined): 0,1,0 with no reg_write/mem_write and instr_retired unchanged. Then 111111: reaches 12, halted=1, pc_en=0 held for 10 cycles.
- Assert rst for one cycle while in MEMWR (state 5): mem_write=0 that cycle, next state 0, instr_retired=0.
- Preload counter path: run 3 sw instructions, then j. Expect instr_retired=4 and pc_source=10 with pc_en=1 in state 11.
